// File: rtl/branch_pred_ctrl.sv
// Branch predictor (2-bit saturating counters) with mispredict flush/redirect sequencing.
// Define BRANCH_STATS_EN to add saturating br_cnt / misp_cnt statistics outputs.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

module branch_pred_ctrl #(
    parameter int IDX_BITS    = 6,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [`REG_SIZE-1:0] if_pc,
    output logic                 pred_taken,
    input  logic                 stall,
    input  logic                 ex_vld,
    input  logic [`REG_SIZE-1:0] ex_pc,
    input  logic                 ex_pred,
    input  logic                 ex_taken,
    input  logic [`REG_SIZE-1:0] ex_target,
    output logic                 flush,
    output logic                 redir_vld,
    output logic [`REG_SIZE-1:0] redir_pc,
    output logic                 busy
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]          br_cnt,
    output logic [31:0]          misp_cnt
`endif
);
    localparam int ENTRIES = 1 << IDX_BITS;

    typedef enum logic [1:0] {IDLE, RECOVER, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic [1:0]            tbl [ENTRIES];
    logic [IDX_BITS-1:0]   rd_idx, wr_idx;
    logic                  accept, mispredict;
    logic                  unused_pc_bits;

    assign rd_idx         = if_pc[IDX_BITS+1:2];
    assign wr_idx         = ex_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{if_pc[`REG_SIZE-1:IDX_BITS+2], if_pc[1:0]};

    // Combinational read of the registered table: a same-cycle write is not visible.
    assign pred_taken = tbl[rd_idx][1];

    assign accept     = ex_vld & ~stall & (state == IDLE);
    assign mispredict = accept & (ex_taken != ex_pred);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) tbl[i] <= 2'b01;
        end else if (accept) begin
            if (ex_taken && tbl[wr_idx] != 2'b11)
                tbl[wr_idx] <= tbl[wr_idx] + 2'b01;
            else if (!ex_taken && tbl[wr_idx] != 2'b00)
                tbl[wr_idx] <= tbl[wr_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            redir_pc <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (mispredict)
                redir_pc <= ex_taken ? ex_target : ex_pc + `REG_SIZE'(4);
        end
    end

    // Busy spans FLUSH_DEPTH cycles: one RECOVER cycle plus FLUSH_DEPTH-1 DRAIN cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mispredict) state_nxt = RECOVER;
            end
            RECOVER: begin
                cnt_nxt   = 4'(FLUSH_DEPTH - 1);
                state_nxt = (FLUSH_DEPTH == 1) ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (cnt <= 4'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign flush     = (state == RECOVER);
    assign redir_vld = (state == RECOVER);
    assign busy      = (state != IDLE);

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt   <= '0;
            misp_cnt <= '0;
        end else begin
            if (accept && br_cnt != 32'hFFFF_FFFF)       br_cnt   <= br_cnt + 32'd1;
            if (mispredict && misp_cnt != 32'hFFFF_FFFF) misp_cnt <= misp_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl; redirect addresses are checked through a scoreboard queue.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

module tb_branch_pred_ctrl;
    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [`REG_SIZE-1:0] if_pc;
    logic                 pred_taken;
    logic                 stall;
    logic                 ex_vld;
    logic [`REG_SIZE-1:0] ex_pc;
    logic                 ex_pred;
    logic                 ex_taken;
    logic [`REG_SIZE-1:0] ex_target;
    logic                 flush;
    logic                 redir_vld;
    logic [`REG_SIZE-1:0] redir_pc;
    logic                 busy;
`ifdef BRANCH_STATS_EN
    logic [31:0]          br_cnt;
    logic [31:0]          misp_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q [$];

    branch_pred_ctrl dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
        .stall(stall), .ex_vld(ex_vld), .ex_pc(ex_pc), .ex_pred(ex_pred),
        .ex_taken(ex_taken), .ex_target(ex_target), .flush(flush),
        .redir_vld(redir_vld), .redir_pc(redir_pc), .busy(busy)
`ifdef BRANCH_STATS_EN
        , .br_cnt(br_cnt), .misp_cnt(misp_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr_ex();
        ex_vld    = 1'b0;
        ex_pred   = 1'b0;
        ex_taken  = 1'b0;
        ex_pc     = '0;
        ex_target = '0;
    endtask

    // Present a branch in EX; when it is expected to be accepted as a mispredict, queue its redirect.
    task automatic br(input logic [31:0] pc, input logic p, input logic t,
                      input logic [31:0] tgt, input logic exp_acc);
        logic [31:0] seq;
        ex_vld    = 1'b1;
        ex_pc     = pc;
        ex_pred   = p;
        ex_taken  = t;
        ex_target = tgt;
        seq       = pc + 32'd4;
        if (exp_acc && p != t) exp_q.push_back(t ? tgt : seq);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        stall = 1'b0;
        clr_ex();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Every redirect must match the next queued address; an unqueued one is an error.
    always @(negedge clk) begin
        if (rst_n && redir_vld) begin
            if (exp_q.size() == 0) chk("unexpected_redirect", 32'(redir_vld), 32'd0);
            else                   chk("sb_redir_pc", redir_pc, exp_q.pop_front());
        end
    end

    initial begin
        if_pc = 32'h40;
        reset_dut();

        // Reset state
        smp();
        chk("rst_pred", 32'(pred_taken), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_redir_vld", 32'(redir_vld), 0);
        chk("rst_redir_pc", redir_pc, 0);
        chk("rst_busy", 32'(busy), 0);
`ifdef BRANCH_STATS_EN
        chk("rst_br_cnt", br_cnt, 0);
        chk("rst_misp_cnt", misp_cnt, 0);
`endif
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'(i) << 2;
            #1 chk("rst_tbl_msb", 32'(pred_taken), 0);
        end
        tick();

        // Taken branches saturate at 11; first accept also checks no same-cycle bypass
        if_pc = 32'h40;
        for (int k = 0; k < 4; k++) begin
            br(32'h40, 1'b1, 1'b1, 32'h80, 1'b1);
            smp();
            if (k == 0) chk("no_bypass", 32'(pred_taken), 0);
            tick();
            clr_ex();
            #1 chk("taken_pred", 32'(pred_taken), 1);
        end
        br(32'h40, 1'b0, 1'b0, 32'h80, 1'b1);
        tick();
        clr_ex();
        #1 chk("sat_then_dec", 32'(pred_taken), 1);
        smp();
        chk("correct_no_flush", 32'(flush), 0);
        tick();

        // Taken mispredict: redirect to target, BUSY for FLUSH_DEPTH cycles
        br(32'h100, 1'b0, 1'b1, 32'h200, 1'b1);
        smp();
        chk("misp_t_flush", 32'(flush), 0);
        tick();
        clr_ex();
        smp();
        chk("misp_t1_flush", 32'(flush), 1);
        chk("misp_t1_redir_vld", 32'(redir_vld), 1);
        chk("misp_t1_redir_pc", redir_pc, 32'h200);
        chk("misp_t1_busy", 32'(busy), 1);
        tick();
        smp();
        chk("misp_t2_flush", 32'(flush), 0);
        chk("misp_t2_redir_vld", 32'(redir_vld), 0);
        chk("misp_t2_busy", 32'(busy), 1);
        tick();
        smp();
        chk("misp_t3_busy", 32'(busy), 0);
        tick();

        // Not-taken mispredict at top of address space wraps to 0
        br(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1234, 1'b1);
        tick();
        clr_ex();
        smp();
        chk("wrap_redir_vld", 32'(redir_vld), 1);
        chk("wrap_redir_pc", redir_pc, 32'h0);
        repeat (2) tick();

        // Branch presented during RECOVER/DRAIN is ignored
        reset_dut();
        if_pc = 32'h300;
        br(32'h300, 1'b0, 1'b1, 32'h400, 1'b1);
        tick();
        br(32'h300, 1'b1, 1'b0, 32'h500, 1'b0);
        smp();
        chk("drain_t1_flush", 32'(flush), 1);
        tick();
        smp();
        chk("drain_t2_flush", 32'(flush), 0);
        chk("drain_t2_busy", 32'(busy), 1);
        tick();
        clr_ex();
        smp();
        chk("drain_t3_busy", 32'(busy), 0);
        chk("drain_t3_flush", 32'(flush), 0);
        chk("drain_tbl_kept", 32'(pred_taken), 1);
`ifdef BRANCH_STATS_EN
        chk("drain_misp_cnt", misp_cnt, 1);
        chk("drain_br_cnt", br_cnt, 1);
`endif
        tick();

        // STALL holds off acceptance until it drops
        stall = 1'b1;
        br(32'h500, 1'b0, 1'b1, 32'h600, 1'b0);
        smp();
        chk("stall_t_flush", 32'(flush), 0);
        tick();
        smp();
        chk("stall_t1_flush", 32'(flush), 0);
        chk("stall_t1_busy", 32'(busy), 0);
        tick();
        stall = 1'b0;
        br(32'h500, 1'b0, 1'b1, 32'h600, 1'b1);
        smp();
        chk("stall_t2_flush", 32'(flush), 0);
        tick();
        clr_ex();
        smp();
        chk("stall_t3_flush", 32'(flush), 1);
        chk("stall_t3_redir_pc", redir_pc, 32'h600);
        repeat (2) tick();

        // Reset asserted in RECOVER clears outputs at once
        br(32'h700, 1'b1, 1'b0, 32'h900, 1'b1);
        tick();
        clr_ex();
        smp();
        chk("abort_pre_flush", 32'(flush), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_flush", 32'(flush), 0);
        chk("abort_redir_vld", 32'(redir_vld), 0);
        chk("abort_redir_pc", redir_pc, 0);
        chk("abort_busy", 32'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
